// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button synchronizers + run/pause/stop FSM + tick prescaler.
// Latency: button to state change SYNC_STAGES edges (+DEBOUNCE_CYCLES with debounce).
// Backpressure: none; events and ticks are one-cycle pulses that are never stalled.
// Optional debouncer: define STOPWATCH_CTRL_DEBOUNCE_EN.
module stopwatch_ctrl #(
   parameter int CLK_HZ          = 100_000_000,
   parameter int TICK_HZ         = 100,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   output logic       count_en,
   output logic       count_clr,
   output logic [1:0] state,
   output logic       running,
   output logic       paused
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUN     = 2'b01,
      PAUSED  = 2'b10,
      STOPPED = 2'b11
   } state_t;

   // Elaboration guard against unusable configurations.
   if (DIV < 2 || SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
      $error("stopwatch_ctrl: illegal parameter combination");
   end

   state_t state_q, state_d;

   // Button bit order: [0]=start, [1]=stop, [2]=pause.
   logic [2:0]                  btn;
   logic [2:0][SYNC_STAGES-1:0] sync_q;
   logic [2:0]                  lvl;
   logic [2:0]                  lvl_d;
   logic [2:0]                  ev;
   logic                        ev_start, ev_stop, ev_pause;
   logic                        clr_d;
   logic [CW-1:0]               cnt;

   assign btn = {pause, stop, start};

   // Shift each raw button level through its synchronizer chain.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         for (int b = 0; b < 3; b++) begin
            sync_q[b] <= {sync_q[b][SYNC_STAGES-2:0], btn[b]};
         end
      end
   end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);

   logic [2:0]          deb_q;
   logic [2:0][DW-1:0]  deb_cnt;

   // Accept a new level only after it has differed for DEBOUNCE_CYCLES straight cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         deb_q   <= '0;
         deb_cnt <= '0;
      end else begin
         for (int b = 0; b < 3; b++) begin
            if (sync_q[b][SYNC_STAGES-1] != deb_q[b]) begin
               if (deb_cnt[b] == DEB_MAX) begin
                  deb_q[b]   <= sync_q[b][SYNC_STAGES-1];
                  deb_cnt[b] <= '0;
               end else begin
                  deb_cnt[b] <= deb_cnt[b] + 1'b1;
               end
            end else begin
               deb_cnt[b] <= '0;
            end
         end
      end
   end

   assign lvl = deb_q;
`else
   // Synchronized level feeds edge detection directly.
   always_comb begin
      lvl = '0;
      for (int b = 0; b < 3; b++) begin
         lvl[b] = sync_q[b][SYNC_STAGES-1];
      end
   end
`endif

   // Delayed copy of the level for rising-edge detection.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lvl_d <= '0;
      end else begin
         lvl_d <= lvl;
      end
   end

   // Rising edges, then keep only the highest-priority one: stop > pause > start.
   assign ev       = lvl & ~lvl_d;
   assign ev_stop  = ev[1];
   assign ev_pause = ev[2] & ~ev[1];
   assign ev_start = ev[0] & ~ev[1] & ~ev[2];

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic; clr_d flags the two transitions that zero the time.
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (ev_start) state_d = RUN;
         end
         RUN: begin
            if (ev_stop)       state_d = STOPPED;
            else if (ev_pause) state_d = PAUSED;
         end
         PAUSED: begin
            if (ev_stop)                  state_d = STOPPED;
            else if (ev_pause || ev_start) state_d = RUN;
         end
         STOPPED: begin
            if (ev_stop) begin
               state_d = IDLE;
               clr_d   = 1'b1;
            end else if (ev_start) begin
               state_d = RUN;
               clr_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs decoded from the current state.
   always_comb begin
      state   = state_q;
      running = (state_q == RUN);
      paused  = (state_q == PAUSED);
   end

   // Prescaler and registered pulses; decisions use the pre-edge state so a due tick survives leaving RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         count_en  <= 1'b0;
         count_clr <= 1'b0;
      end else begin
         count_clr <= clr_d;
         case (state_q)
            RUN: begin
               if (cnt == CNT_MAX) begin
                  cnt      <= '0;
                  count_en <= 1'b1;
               end else begin
                  cnt      <= cnt + 1'b1;
                  count_en <= 1'b0;
               end
            end
            PAUSED: begin
               count_en <= 1'b0;
            end
            default: begin
               cnt      <= '0;
               count_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed bench for stopwatch_ctrl with DIV=10, two sync stages.
// Latency: stimulus applied 1 ns after a rising edge, outputs sampled at the same point.
// Backpressure: not applicable.
module tb_stopwatch_ctrl;

   logic       clk   = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       stop  = 1'b0;
   logic       pause = 1'b0;
   logic       count_en, count_clr, running, paused;
   logic [1:0] state;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   stopwatch_ctrl #(
      .CLK_HZ(100), .TICK_HZ(10), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
      .count_en(count_en), .count_clr(count_clr), .state(state),
      .running(running), .paused(paused)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise buttons {pause,stop,start}; returns just after the edge where the state changes.
   task automatic press(input logic [2:0] b);
      {pause, stop, start} = b;
      tick(); tick(); tick();
   endtask

   task automatic release_btns();
      {pause, stop, start} = 3'b000;
      tick(); tick(); tick();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      tests++;
      if ({state, count_en, count_clr, running, paused} !== 6'b0) begin
         fails++;
         $display("FAIL reset_hold: outs=%b expected 000000", {state, count_en, count_clr, running, paused});
      end
      reset = 1'b0;
      tick(); tick(); tick(); tick(); tick();
      tests++;
      if ({state, count_en, count_clr, running, paused} !== 6'b0) begin
         fails++;
         $display("FAIL reset_release: outs=%b expected 000000", {state, count_en, count_clr, running, paused});
      end
   endtask

   task automatic test_start_tick();
      start = 1'b1;
      tick();
      tests++;
      if (state !== 2'b00) begin fails++; $display("FAIL start_e0: state=%b expected 00", state); end
      tick();
      tests++;
      if (state !== 2'b00) begin fails++; $display("FAIL start_e1: state=%b expected 00", state); end
      tick();
      tests++;
      if (state !== 2'b01 || running !== 1'b1) begin
         fails++; $display("FAIL start_e2: state=%b running=%b expected 01/1", state, running);
      end
      start = 1'b0;
      for (int i = 1; i <= 30; i++) begin
         tick();
         tests++;
         if (count_en !== ((i % 10) == 0) || state !== 2'b01) begin
            fails++;
            $display("FAIL tick_spacing[%0d]: count_en=%b state=%b expected %b/01", i, count_en, state, (i % 10) == 0);
         end
      end
   endtask

   task automatic test_pause_resume();
      tick();
      pause = 1'b1;
      tick(); tick();
      tests++;
      if (state !== 2'b01) begin fails++; $display("FAIL pause_early: state=%b expected 01", state); end
      tick();
      tests++;
      if (state !== 2'b10 || paused !== 1'b1 || count_en !== 1'b0) begin
         fails++; $display("FAIL pause_enter: state=%b paused=%b en=%b expected 10/1/0", state, paused, count_en);
      end
      tick(); tick();
      pause = 1'b0;
      for (int i = 1; i <= 38; i++) begin
         tick();
         tests++;
         if (state !== 2'b10 || count_en !== 1'b0) begin
            fails++; $display("FAIL pause_hold[%0d]: state=%b en=%b expected 10/0", i, state, count_en);
         end
      end
      start = 1'b1;
      tick(); tick(); tick();
      tests++;
      if (state !== 2'b01 || count_en !== 1'b0) begin
         fails++; $display("FAIL resume_enter: state=%b en=%b expected 01/0", state, count_en);
      end
      for (int i = 1; i <= 16; i++) begin
         tick();
         tests++;
         if (count_en !== (i == 6 || i == 16)) begin
            fails++; $display("FAIL resume_tick[%0d]: count_en=%b expected %b", i, count_en, (i == 6 || i == 16));
         end
      end
      start = 1'b0;
   endtask

   task automatic test_stop_clear();
      press(3'b010);
      tests++;
      if (state !== 2'b11 || count_clr !== 1'b0) begin
         fails++; $display("FAIL stop_enter: state=%b clr=%b expected 11/0", state, count_clr);
      end
      stop = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         tests++;
         if (state !== 2'b11 || count_clr !== 1'b0 || count_en !== 1'b0) begin
            fails++; $display("FAIL stopped_hold[%0d]: state=%b clr=%b en=%b expected 11/0/0", i, state, count_clr, count_en);
         end
      end
      press(3'b010);
      tests++;
      if (state !== 2'b00 || count_clr !== 1'b1) begin
         fails++; $display("FAIL stop_to_idle: state=%b clr=%b expected 00/1", state, count_clr);
      end
      tick();
      tests++;
      if (state !== 2'b00 || count_clr !== 1'b0) begin
         fails++; $display("FAIL idle_clr_width: state=%b clr=%b expected 00/0", state, count_clr);
      end
      release_btns();
      press(3'b001);
      tests++;
      if (state !== 2'b01 || count_clr !== 1'b0) begin
         fails++; $display("FAIL idle_to_run: state=%b clr=%b expected 01/0", state, count_clr);
      end
      release_btns();
      press(3'b010);
      tests++;
      if (state !== 2'b11) begin fails++; $display("FAIL run_to_stop: state=%b expected 11", state); end
      release_btns();
      press(3'b001);
      tests++;
      if (state !== 2'b01 || count_clr !== 1'b1 || count_en !== 1'b0) begin
         fails++; $display("FAIL restart: state=%b clr=%b en=%b expected 01/1/0", state, count_clr, count_en);
      end
      for (int i = 1; i <= 10; i++) begin
         tick();
         tests++;
         if (count_clr !== 1'b0 || count_en !== (i == 10)) begin
            fails++; $display("FAIL restart_tick[%0d]: clr=%b en=%b expected 0/%b", i, count_clr, count_en, i == 10);
         end
      end
      release_btns();
   endtask

   task automatic test_priority();
      press(3'b111);
      tests++;
      if (state !== 2'b11) begin fails++; $display("FAIL prio_all: state=%b expected 11", state); end
      release_btns();
      press(3'b001);
      release_btns();
      press(3'b100);
      tests++;
      if (state !== 2'b10) begin fails++; $display("FAIL prio_setup_pause: state=%b expected 10", state); end
      release_btns();
      press(3'b101);
      tests++;
      if (state !== 2'b01) begin fails++; $display("FAIL prio_pause_start: state=%b expected 01", state); end
      release_btns();
   endtask

   task automatic test_reset_mid_run();
      bit found = 1'b0;
      for (int i = 0; i < 15 && !found; i++) begin
         tick();
         if (count_en === 1'b1) found = 1'b1;
      end
      tests++;
      if (!found) begin fails++; $display("FAIL midrun_tick: no count_en within 15 cycles, expected one"); end
      reset = 1'b1;
      #1;
      tests++;
      if ({state, count_en, count_clr, running, paused} !== 6'b0) begin
         fails++; $display("FAIL midrun_reset: outs=%b expected 000000", {state, count_en, count_clr, running, paused});
      end
      tick(); tick();
      reset = 1'b0;
      for (int i = 1; i <= 50; i++) begin
         tick();
         tests++;
         if (state !== 2'b00 || count_en !== 1'b0 || count_clr !== 1'b0) begin
            fails++; $display("FAIL post_reset_idle[%0d]: state=%b en=%b clr=%b expected 00/0/0", i, state, count_en, count_clr);
         end
      end
      reset = 1'b1;
      start = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      tests++;
      if (state !== 2'b00) begin fails++; $display("FAIL held_across_reset_early: state=%b expected 00", state); end
      tick();
      tests++;
      if (state !== 2'b01) begin fails++; $display("FAIL held_across_reset: state=%b expected 01", state); end
      release_btns();
   endtask

   task automatic test_debounce_glitch();
      start = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      start = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         tests++;
         if (state !== 2'b00) begin fails++; $display("FAIL deb_glitch[%0d]: state=%b expected 00", i, state); end
      end
   endtask

   task automatic test_debounce_held();
      start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         tick();
         tests++;
         if (state !== ((k >= 11) ? 2'b01 : 2'b00)) begin
            fails++; $display("FAIL deb_held[%0d]: state=%b expected %b", k, state, (k >= 11) ? 2'b01 : 2'b00);
         end
      end
      start = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      tests++;
      if (state !== 2'b01) begin fails++; $display("FAIL deb_after_release: state=%b expected 01", state); end
   endtask

   initial begin
      test_reset();
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
      test_debounce_glitch();
      test_debounce_held();
`else
      test_start_tick();
      test_pause_resume();
      test_stop_clear();
      test_priority();
      test_reset_mid_run();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Run-control sequencer for the stopwatch datapath. It synchronizes the raw start/stop/pause button levels and turns their rising edges into events. A four-state FSM consumes those events and drives the time counter. It emits a one-cycle count enable at TICK_HZ while running, and a one-cycle clear pulse whenever the elapsed time must return to zero. It sits between the board buttons and the BCD time counter / display path in stopwatch_top.

## Interface
- CLK_HZ, 100_000_000: input clock frequency.
- TICK_HZ, 100: count-enable rate (centiseconds). DIV = CLK_HZ/TICK_HZ; DIV must be an integer ≥ 2.
- SYNC_STAGES, 2: flops per button synchronizer, ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000: stable-level requirement. Used only with STOPWATCH_CTRL_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; one clock domain.
- start  in  1  raw button level, asynchronous.
- stop  in  1  raw button level, asynchronous.
- pause  in  1  raw button level, asynchronous.
- count_en  out  1  registered one-cycle tick to the time counter.
- count_clr  out  1  registered one-cycle clear to the time counter.
- state  out  2  current FSM state.
- running  out  1  state==RUN.
- paused  out  1  state==PAUSED.

## Operation
- **Synchronizer:** each button passes through a SYNC_STAGES flop chain. The event pulse is the synchronized level AND NOT its one-cycle-delayed copy. Only rising edges create events; held buttons create one event.
- **FSM states:** IDLE=2'b00, RUN=2'b01, PAUSED=2'b10, STOPPED=2'b11.
- **Event priority** when events coincide in one cycle: stop > pause > start. Only the highest-priority event is acted on; the others are dropped.
- **IDLE:**
  - start → RUN.
  - stop and pause ignored.
- **RUN:**
  - stop → STOPPED.
  - pause → PAUSED.
  - start ignored.
- **PAUSED:**
  - stop → STOPPED.
  - pause or start → RUN (resume, prescaler keeps its value).
- **STOPPED:**
  - stop → IDLE with count_clr.
  - start → RUN with count_clr and prescaler cleared (restart from zero).
  - pause ignored.
- **Prescaler cnt:** width $clog2(DIV). Updates use the pre-edge state.
  - In RUN: if cnt==DIV-1 then cnt←0 and count_en←1; else cnt←cnt+1 and count_en←0.
  - In PAUSED: cnt holds and count_en←0.
  - In IDLE and STOPPED: cnt←0 and count_en←0.
- **Tick on the edge that leaves RUN:** a tick due on that edge is still issued.
- **count_clr:** high for exactly the first cycle of the new state on STOPPED→IDLE and STOPPED→RUN. Low otherwise.

## Timing
- **Reset values:**
  - state=IDLE, cnt=0.
  - count_en=0, count_clr=0, running=0, paused=0.
  - All synchronizer and edge flops 0.
- **Event latency:** a button first sampled high at edge E0 changes state at edge E0+SYNC_STAGES.
- **Tick spacing:** entering RUN from IDLE/STOPPED at edge E, count_en is high in the cycle after edge E+DIV, then every DIV cycles.
- **Resume:** resuming at edge R with held cnt=k gives the first count_en after edge R+(DIV-k).
- **Reset mid-operation:** state returns to IDLE immediately (asynchronous). No count_clr pulse is generated; the counter has its own reset. A button held across reset deassertion produces one event, changing state SYNC_STAGES edges after the first post-reset edge.

## Configuration
- **STOPWATCH_CTRL_DEBOUNCE_EN defined:**
  - Each synchronized level feeds a debouncer. The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - Edge detection runs on the debounced level.
  - Event latency grows by DEBOUNCE_CYCLES.
- **Undefined:** no debouncer logic; the synchronized level feeds edge detection directly. DEBOUNCE_CYCLES is unused.

## Test plan
Bench parameters: CLK_HZ=100, TICK_HZ=10 (DIV=10), SYNC_STAGES=2, debounce off unless noted.
- Assert reset mid-RUN → state=00, all outputs 0 immediately. Release with no buttons → stays IDLE and no count_en for 50 cycles.
- start high 3 cycles from IDLE → state=01 two edges after first sample. count_en pulses 10 cycles apart, first after edge E+10. Exactly one event per press.
- RUN for 4 ticks of cnt (cnt=4), press pause → state=10 and no count_en for 40 cycles. Press start → state=01, first count_en after R+6.
- In RUN press stop → state=11 with count_clr=0. Press stop again → state=00 with count_clr high exactly one cycle. Press start then stop, then start from STOPPED → state=01 with count_clr one cycle and first tick after E+10.
- In RUN raise start, stop and pause on the same cycle → state=11, not PAUSED. In PAUSED raise pause and start together → state=01.
- With STOPWATCH_CTRL_DEBOUNCE_EN and DEBOUNCE_CYCLES=8:
  - start glitch of 5 cycles → no state change.
  - Press held 12 cycles → state=01 at E0+2+8.
